note_player: RTL and testbench
==============================

NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 Parameter NOTE_W SHALL default 6: width of the note index.
REQ-002 Parameter DUR_W SHALL default 6: width of the duration, counted in beats.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 play_enable  input  1  1 = playing; 0 = pause (all state frozen).
REQ-006 note_to_load  input  NOTE_W  note index; 0 = rest.
REQ-007 duration_to_load  input  DUR_W  note length in beats.
REQ-008 load_new_note  input  1  single-cycle pulse that loads a note and its duration.
REQ-009 beat  input  1  single-cycle beat tick.
REQ-010 generate_next_sample  input  1  single-cycle sample request from the codec side.
REQ-011 done_with_note  output  1  single-cycle pulse when the current note expires.
REQ-012 step_size  output  20  unsigned 10.10 fixed-point phase step, to sine_reader.
REQ-013 generate_next  output  1  single-cycle sample request, to sine_reader.
REQ-014 sine_sample_ready  input  1  sine_reader sample-valid pulse.
REQ-015 sine_sample  input  16  sine_reader signed sample.
REQ-016 sample_out  output  16  signed sample, held between updates.
REQ-017 new_sample_ready  output  1  single-cycle pulse: sample_out has been updated.

Function
REQ-018 The FSM SHALL have two states: IDLE and PLAYING.
REQ-019 When load_new_note=1, in either state, the block SHALL latch the note, set the remaining-beat counter to duration_to_load and enter PLAYING on the next edge.
REQ-020 A load SHALL override any note in progress, including a note on the cycle its done_with_note would otherwise fire; that done_with_note SHALL be suppressed.
REQ-021 step_size SHALL equal frequency_rom[note] one cycle after the load and SHALL hold until the next load; a rest SHALL give 0.
REQ-022 In PLAYING with play_enable=1, each beat SHALL decrement the counter.
REQ-023 Count expiry:
- trigger: a beat that takes the counter 1->0;
- response: done_with_note=1 for exactly one cycle on the next edge;
- state: return to IDLE.
REQ-024 A load with duration 0 SHALL give done_with_note one cycle after entering PLAYING, with no beat required.
REQ-025 If load_new_note and beat arrive in the same cycle, the load SHALL win and that beat SHALL be ignored.
REQ-026 Sample request forwarding:
- condition: PLAYING, play_enable=1, note!=0;
- response: generate_next_sample SHALL produce generate_next=1 exactly one cycle later.
REQ-027 On sine_sample_ready=1, sample_out SHALL take sine_sample and new_sample_ready SHALL pulse on the same edge.
REQ-028 In IDLE, or for a rest note, generate_next_sample SHALL give sample_out=0 and new_sample_ready one cycle later; generate_next SHALL stay 0.
REQ-029 With play_enable=0:
- the counter, FSM, step_size and sample_out SHALL hold;
- beat and generate_next_sample SHALL be ignored;
- a pending sine_sample_ready SHALL still be captured.
REQ-030 A request arriving while a sine response is outstanding SHALL be dropped; at most one request may be outstanding.

Reset
REQ-031 On reset:
- FSM = IDLE; counter = 0; note = 0;
- step_size = 0; sample_out = 0;
- generate_next, new_sample_ready and done_with_note = 0.
REQ-032 Reset mid-note SHALL abandon the note without a done_with_note pulse and SHALL clear any outstanding request.

Configuration
REQ-033 Macro NOTE_PLAYER_DECAY_EN, when defined: while PLAYING with counter==1, sample_out SHALL be sine_sample arithmetically shifted right by 1 (-6 dB final beat).
REQ-034 Without NOTE_PLAYER_DECAY_EN, sample_out SHALL always be the unmodified sine_sample.

Structure
REQ-035 A shared package note_pkg SHALL hold:
- NOTE_W and DUR_W;
- the step width 20 and the fractional-bit count 10;
- the REST index 0;
- the FSM state enum.
REQ-036 Sub-module frequency_rom SHALL be a registered, 64-entry x 20-bit step table, indexed by note.

Verification
REQ-037 Load note 0, duration 2, then 2 beats -> step_size=0; sample requests return sample_out=0; done_with_note fires 1 cycle after the 2nd beat.
REQ-038 Load note 5, duration 3; request a sample; stub sine_reader returns 16'h1234 -> generate_next 1 cycle after the request; sample_out=16'h1234 with new_sample_ready on the ready cycle.
REQ-039 Load duration 4; drop play_enable for 3 beats, then raise it and send 4 beats -> the counter holds during the pause; done_with_note only after the 4th enabled beat.
REQ-040 load_new_note (duration 2) coincident with the expiring beat of the previous note -> no done_with_note; a new done_with_note after 2 further beats.
REQ-041 Assert reset mid-note with a request outstanding -> all outputs 0 within the same cycle; no done_with_note after release.
REQ-042 With NOTE_PLAYER_DECAY_EN: final beat of a note, sine_sample=16'sd1000 -> sample_out=16'sd500; earlier beats -> 1000.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared constants and FSM state type for the note player and its frequency table.
package note_pkg;
    localparam int NOTE_W    = 6;
    localparam int DUR_W     = 6;
    localparam int STEP_W    = 20;
    localparam int STEP_FRAC = 10;
    localparam int SAMPLE_W  = 16;
    localparam int REST      = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;
endpackage

// File: rtl/note_player_if.sv
// Note player bus: note loading, beat/sample ticks, and the sine_reader handshake.
interface note_player_if #(
    parameter int NOTE_W = note_pkg::NOTE_W,
    parameter int DUR_W  = note_pkg::DUR_W
);
    import note_pkg::*;

    logic                       play_enable;
    logic [NOTE_W-1:0]          note_to_load;
    logic [DUR_W-1:0]           duration_to_load;
    logic                       load_new_note;
    logic                       beat;
    logic                       generate_next_sample;
    logic                       done_with_note;
    logic [STEP_W-1:0]          step_size;
    logic                       generate_next;
    logic                       sine_sample_ready;
    logic signed [SAMPLE_W-1:0] sine_sample;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       new_sample_ready;

    modport master (
        output play_enable, note_to_load, duration_to_load, load_new_note, beat,
               generate_next_sample, sine_sample_ready, sine_sample,
        input  done_with_note, step_size, generate_next, sample_out, new_sample_ready
    );

    modport slave (
        input  play_enable, note_to_load, duration_to_load, load_new_note, beat,
               generate_next_sample, sine_sample_ready, sine_sample,
        output done_with_note, step_size, generate_next, sample_out, new_sample_ready
    );
endinterface

// File: rtl/note_player_frequency_rom.sv
// Registered 64-entry phase-step table (10.10 fixed point); note 1 = A0, note 49 = A4, 48 kHz.
module frequency_rom #(
    parameter int NOTE_W = note_pkg::NOTE_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [NOTE_W-1:0]          note,
    output logic [note_pkg::STEP_W-1:0] step
);
    import note_pkg::*;

    // Top-octave steps; lower octaves are exact right shifts of these.
    function automatic logic [STEP_W-1:0] step_for(input logic [NOTE_W-1:0] n);
        int idx;
        logic [STEP_W-1:0] base;
        idx = int'(n) - 1;
        case (idx % 12)
            1:       base = 20'd20367;
            2:       base = 20'd21578;
            3:       base = 20'd22861;
            4:       base = 20'd24221;
            5:       base = 20'd25661;
            6:       base = 20'd27187;
            7:       base = 20'd28803;
            8:       base = 20'd30516;
            9:       base = 20'd32331;
            10:      base = 20'd34253;
            11:      base = 20'd36290;
            default: base = 20'd19224;
        endcase
        if (n == NOTE_W'(REST))
            return '0;
        return base >> (5 - idx / 12);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            step <= '0;
        else if (load)
            step <= step_for(note);
    end
endmodule

// File: rtl/note_player.sv
// Note sequencer: times a note in beats, forwards sample requests to sine_reader.
// Optional NOTE_PLAYER_DECAY_EN halves the sample amplitude on a note's final beat.
module note_player #(
    parameter int NOTE_W = note_pkg::NOTE_W,
    parameter int DUR_W  = note_pkg::DUR_W
) (
    input  logic          clk,
    input  logic          reset,
    note_player_if.slave  bus
);
    import note_pkg::*;

    state_t                     state;
    logic [DUR_W-1:0]           count;
    logic [NOTE_W-1:0]          note;
    logic                       pending;
    logic                       rom_load;
    logic signed [SAMPLE_W-1:0] captured;

    assign rom_load = bus.play_enable & bus.load_new_note;

    frequency_rom #(.NOTE_W(NOTE_W)) u_rom (
        .clk   (clk),
        .reset (reset),
        .load  (rom_load),
        .note  (bus.note_to_load),
        .step  (bus.step_size)
    );

    always_comb begin
        captured = bus.sine_sample;
`ifdef NOTE_PLAYER_DECAY_EN
        if (state == PLAYING && count == DUR_W'(1))
            captured = bus.sine_sample >>> 1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            count                <= '0;
            note                 <= '0;
            pending              <= 1'b0;
            bus.sample_out       <= '0;
            bus.generate_next    <= 1'b0;
            bus.new_sample_ready <= 1'b0;
            bus.done_with_note   <= 1'b0;
        end else begin
            bus.generate_next    <= 1'b0;
            bus.new_sample_ready <= 1'b0;
            bus.done_with_note   <= 1'b0;

            if (bus.play_enable) begin
                // A load takes priority over a coincident beat or expiry.
                if (bus.load_new_note) begin
                    note  <= bus.note_to_load;
                    count <= bus.duration_to_load;
                    state <= PLAYING;
                end else if (state == PLAYING) begin
                    if (count == '0) begin
                        bus.done_with_note <= 1'b1;
                        state              <= IDLE;
                    end else if (bus.beat) begin
                        count <= count - DUR_W'(1);
                        if (count == DUR_W'(1)) begin
                            bus.done_with_note <= 1'b1;
                            state              <= IDLE;
                        end
                    end
                end

                if (bus.generate_next_sample) begin
                    if (state == PLAYING && note != NOTE_W'(REST)) begin
                        if (!pending) begin
                            bus.generate_next <= 1'b1;
                            pending           <= 1'b1;
                        end
                    end else begin
                        bus.sample_out       <= '0;
                        bus.new_sample_ready <= 1'b1;
                    end
                end
            end

            // Responses are captured even while paused.
            if (bus.sine_sample_ready) begin
                bus.sample_out       <= captured;
                bus.new_sample_ready <= 1'b1;
                pending              <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: directed scenarios plus a randomized run against a cycle model.
module tb_note_player;
    import note_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    note_player_if bus ();
    note_player dut (.clk(clk), .reset(reset), .bus(bus));

    int compared   = 0;
    int mismatched = 0;

    logic              pe, ld, bt, gs, sr;
    logic [5:0]        nt, du;
    logic signed [15:0] ss;

    bit                m_play, m_pend;
    int                m_rem, m_note, m_step_note;
    logic signed [15:0] m_sample;
    bit                e_done, e_gn, e_nsr;

    int                stub_cnt, stub_lat;
    bit                stub_rand;
    logic signed [15:0] stub_data;

    function automatic real ideal_step(int n);
        return 27.5 * $pow(2.0, real'(n - 1) / 12.0) * 1048576.0 / 48000.0;
    endfunction

    function automatic bit step_ok(int n, logic [19:0] got);
        real d;
        if (n == 0) return (got === 20'd0);
        d = real'(got) - ideal_step(n);
        if (d < 0.0) d = -d;
        return (d <= 1.5) && !$isunknown(got);
    endfunction

    task automatic model_clear();
        m_play = 0; m_pend = 0; m_rem = 0; m_note = 0; m_step_note = 0;
        m_sample = '0; stub_cnt = 0;
    endtask

    task automatic run_cycle();
        bit n_play, n_pend;
        int n_rem, n_note, n_step;
        logic signed [15:0] n_sample;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                sr = 1'b1;
                ss = stub_rand ? 16'($urandom) : stub_data;
            end
        end
        bus.play_enable = pe; bus.load_new_note = ld; bus.note_to_load = nt;
        bus.duration_to_load = du; bus.beat = bt; bus.generate_next_sample = gs;
        bus.sine_sample_ready = sr; bus.sine_sample = ss;

        n_play = m_play; n_pend = m_pend; n_rem = m_rem; n_note = m_note;
        n_step = m_step_note; n_sample = m_sample;
        e_done = 0; e_gn = 0; e_nsr = 0;
        if (pe) begin
            if (ld) begin
                n_play = 1; n_rem = int'(du); n_note = int'(nt); n_step = int'(nt);
            end else if (m_play) begin
                if (m_rem == 0) begin
                    e_done = 1; n_play = 0;
                end else if (bt) begin
                    n_rem = m_rem - 1;
                    if (n_rem == 0) begin e_done = 1; n_play = 0; end
                end
            end
            if (gs) begin
                if (m_play && m_note != 0) begin
                    if (!m_pend) begin e_gn = 1; n_pend = 1; end
                end else begin
                    n_sample = '0; e_nsr = 1;
                end
            end
        end
        if (sr) begin
`ifdef NOTE_PLAYER_DECAY_EN
            n_sample = (m_play && m_rem == 1) ? (ss >>> 1) : ss;
`else
            n_sample = ss;
`endif
            e_nsr = 1; n_pend = 0;
        end

        @(posedge clk);
        #1;
        m_play = n_play; m_pend = n_pend; m_rem = n_rem; m_note = n_note;
        m_step_note = n_step; m_sample = n_sample;
        if (e_gn) stub_cnt = stub_rand ? int'($urandom_range(1, 4)) : stub_lat;
        ld = 0; bt = 0; gs = 0; sr = 0;
        bus.load_new_note = 0; bus.beat = 0; bus.generate_next_sample = 0;
        bus.sine_sample_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pe = 1; ld = 0; bt = 0; gs = 0; sr = 0; nt = '0; du = '0; ss = '0;
        bus.play_enable = 1; bus.load_new_note = 0; bus.note_to_load = '0;
        bus.duration_to_load = '0; bus.beat = 0; bus.generate_next_sample = 0;
        bus.sine_sample_ready = 0; bus.sine_sample = '0;
        model_clear();
        stub_rand = 0; stub_lat = 1; stub_data = '0;
        repeat (2) @(posedge clk);
        #1;
        compared += 5;
        if (bus.step_size !== 20'd0) begin mismatched++; $display("FAIL reset step_size: got %0d want 0", bus.step_size); end
        if (bus.sample_out !== 16'd0) begin mismatched++; $display("FAIL reset sample_out: got %h want 0", bus.sample_out); end
        if (bus.generate_next !== 1'b0) begin mismatched++; $display("FAIL reset generate_next: got %b want 0", bus.generate_next); end
        if (bus.new_sample_ready !== 1'b0) begin mismatched++; $display("FAIL reset new_sample_ready: got %b want 0", bus.new_sample_ready); end
        if (bus.done_with_note !== 1'b0) begin mismatched++; $display("FAIL reset done_with_note: got %b want 0", bus.done_with_note); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_sample_path();
        stub_rand = 0; stub_data = 16'h1234; stub_lat = 2;
        ld = 1; nt = 6'd5; du = 6'd3; run_cycle();
        compared++;
        if (!step_ok(5, bus.step_size)) begin mismatched++; $display("FAIL sample_path step_size: got %0d want ~%0.1f", bus.step_size, ideal_step(5)); end
        gs = 1; run_cycle();
        compared++;
        if (bus.generate_next !== 1'b1) begin mismatched++; $display("FAIL sample_path generate_next: got %b want 1", bus.generate_next); end
        gs = 1; run_cycle();
        compared += 2;
        if (bus.generate_next !== 1'b0) begin mismatched++; $display("FAIL sample_path dropped_request: got %b want 0", bus.generate_next); end
        if (bus.new_sample_ready !== 1'b0) begin mismatched++; $display("FAIL sample_path early_ready: got %b want 0", bus.new_sample_ready); end
        run_cycle();
        compared += 2;
        if (bus.sample_out !== 16'h1234) begin mismatched++; $display("FAIL sample_path sample_out: got %h want 1234", bus.sample_out); end
        if (bus.new_sample_ready !== 1'b1) begin mismatched++; $display("FAIL sample_path new_sample_ready: got %b want 1", bus.new_sample_ready); end
        run_cycle();
        compared++;
        if (bus.new_sample_ready !== 1'b0) begin mismatched++; $display("FAIL sample_path ready_pulse_width: got %b want 0", bus.new_sample_ready); end
        gs = 1; run_cycle();
        compared++;
        if (bus.generate_next !== 1'b1) begin mismatched++; $display("FAIL sample_path rerequest: got %b want 1", bus.generate_next); end
        repeat (3) run_cycle();
    endtask

    task automatic test_rest_note();
        ld = 1; nt = 6'd0; du = 6'd2; run_cycle();
        compared++;
        if (bus.step_size !== 20'd0) begin mismatched++; $display("FAIL rest step_size: got %0d want 0", bus.step_size); end
        gs = 1; run_cycle();
        compared += 3;
        if (bus.sample_out !== 16'd0) begin mismatched++; $display("FAIL rest sample_out: got %h want 0", bus.sample_out); end
        if (bus.new_sample_ready !== 1'b1) begin mismatched++; $display("FAIL rest new_sample_ready: got %b want 1", bus.new_sample_ready); end
        if (bus.generate_next !== 1'b0) begin mismatched++; $display("FAIL rest generate_next: got %b want 0", bus.generate_next); end
        bt = 1; run_cycle();
        compared++;
        if (bus.done_with_note !== 1'b0) begin mismatched++; $display("FAIL rest early_done: got %b want 0", bus.done_with_note); end
        bt = 1; run_cycle();
        compared++;
        if (bus.done_with_note !== 1'b1) begin mismatched++; $display("FAIL rest done: got %b want 1", bus.done_with_note); end
        run_cycle();
        compared++;
        if (bus.done_with_note !== 1'b0) begin mismatched++; $display("FAIL rest done_width: got %b want 0", bus.done_with_note); end
    endtask

    task automatic test_pause();
        int dones;
        ld = 1; nt = 6'd7; du = 6'd4; run_cycle();
        pe = 0; dones = 0;
        for (int i = 0; i < 3; i++) begin
            bt = 1; gs = 1; run_cycle();
            dones += int'(bus.done_with_note);
            compared += 2;
            if (bus.generate_next !== 1'b0) begin mismatched++; $display("FAIL pause generate_next: got %b want 0", bus.generate_next); end
            if (bus.new_sample_ready !== 1'b0) begin mismatched++; $display("FAIL pause new_sample_ready: got %b want 0", bus.new_sample_ready); end
        end
        pe = 1;
        for (int i = 1; i <= 4; i++) begin
            bt = 1; run_cycle();
            compared++;
            if (bus.done_with_note !== (i == 4)) begin mismatched++; $display("FAIL pause done beat%0d: got %b want %b", i, bus.done_with_note, i == 4); end
            run_cycle();
            dones += int'(bus.done_with_note);
        end
        compared++;
        if (dones != 0) begin mismatched++; $display("FAIL pause stray_done: got %0d want 0", dones); end
    endtask

    task automatic test_load_override();
        ld = 1; nt = 6'd3; du = 6'd1; run_cycle();
        ld = 1; bt = 1; nt = 6'd9; du = 6'd2; run_cycle();
        compared += 2;
        if (bus.done_with_note !== 1'b0) begin mismatched++; $display("FAIL override suppressed_done: got %b want 0", bus.done_with_note); end
        if (!step_ok(9, bus.step_size)) begin mismatched++; $display("FAIL override step_size: got %0d want ~%0.1f", bus.step_size, ideal_step(9)); end
        bt = 1; run_cycle();
        compared++;
        if (bus.done_with_note !== 1'b0) begin mismatched++; $display("FAIL override early_done: got %b want 0", bus.done_with_note); end
        bt = 1; run_cycle();
        compared++;
        if (bus.done_with_note !== 1'b1) begin mismatched++; $display("FAIL override done: got %b want 1", bus.done_with_note); end
        ld = 1; nt = 6'd20; du = 6'd0; run_cycle();
        run_cycle();
        compared++;
        if (bus.done_with_note !== 1'b1) begin mismatched++; $display("FAIL zero_duration done: got %b want 1", bus.done_with_note); end
    endtask

    task automatic test_reset_mid_note();
        int dones;
        stub_rand = 0; stub_data = 16'h7abc; stub_lat = 1;
        ld = 1; nt = 6'd4; du = 6'd5; run_cycle();
        gs = 1; run_cycle();
        run_cycle();
        stub_lat = 3;
        gs = 1; run_cycle();
        #1 reset = 1'b1;
        #1;
        compared += 5;
        if (bus.step_size !== 20'd0) begin mismatched++; $display("FAIL midreset step_size: got %0d want 0", bus.step_size); end
        if (bus.sample_out !== 16'd0) begin mismatched++; $display("FAIL midreset sample_out: got %h want 0", bus.sample_out); end
        if (bus.generate_next !== 1'b0) begin mismatched++; $display("FAIL midreset generate_next: got %b want 0", bus.generate_next); end
        if (bus.new_sample_ready !== 1'b0) begin mismatched++; $display("FAIL midreset new_sample_ready: got %b want 0", bus.new_sample_ready); end
        if (bus.done_with_note !== 1'b0) begin mismatched++; $display("FAIL midreset done_with_note: got %b want 0", bus.done_with_note); end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            bt = 1; run_cycle();
            dones += int'(bus.done_with_note);
        end
        compared++;
        if (dones != 0) begin mismatched++; $display("FAIL midreset stray_done: got %0d want 0", dones); end
        ld = 1; nt = 6'd11; du = 6'd3; run_cycle();
        gs = 1; run_cycle();
        compared++;
        if (bus.generate_next !== 1'b1) begin mismatched++; $display("FAIL midreset outstanding_cleared: got %b want 1", bus.generate_next); end
        repeat (4) run_cycle();
    endtask

`ifdef NOTE_PLAYER_DECAY_EN
    task automatic test_decay();
        stub_rand = 0; stub_data = 16'sd1000; stub_lat = 1;
        ld = 1; nt = 6'd5; du = 6'd2; run_cycle();
        gs = 1; run_cycle();
        run_cycle();
        compared++;
        if (bus.sample_out !== 16'sd1000) begin mismatched++; $display("FAIL decay early_beat: got %0d want 1000", bus.sample_out); end
        bt = 1; run_cycle();
        gs = 1; run_cycle();
        run_cycle();
        compared++;
        if (bus.sample_out !== 16'sd500) begin mismatched++; $display("FAIL decay final_beat: got %0d want 500", bus.sample_out); end
        bt = 1; run_cycle();
        run_cycle();
    endtask
`endif

    task automatic test_random();
        stub_rand = 1;
        for (int c = 0; c < 400; c++) begin
            pe = ($urandom_range(0, 7) != 0);
            ld = pe && ($urandom_range(0, 9) == 0);
            nt = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            du = 6'($urandom_range(0, 5));
            bt = ($urandom_range(0, 2) == 0);
            gs = ($urandom_range(0, 3) == 0);
            run_cycle();
            compared += 5;
            if (bus.done_with_note !== e_done) begin mismatched++; $display("FAIL random[%0d] done_with_note: got %b want %b", c, bus.done_with_note, e_done); end
            if (bus.generate_next !== e_gn) begin mismatched++; $display("FAIL random[%0d] generate_next: got %b want %b", c, bus.generate_next, e_gn); end
            if (bus.new_sample_ready !== e_nsr) begin mismatched++; $display("FAIL random[%0d] new_sample_ready: got %b want %b", c, bus.new_sample_ready, e_nsr); end
            if (bus.sample_out !== m_sample) begin mismatched++; $display("FAIL random[%0d] sample_out: got %h want %h", c, bus.sample_out, m_sample); end
            if (!step_ok(m_step_note, bus.step_size)) begin mismatched++; $display("FAIL random[%0d] step_size: got %0d want note %0d", c, bus.step_size, m_step_note); end
        end
        pe = 1;
    endtask

    initial begin
        test_reset();
        test_sample_path();
        test_rest_note();
        test_pause();
        test_load_override();
        test_reset_mid_note();
`ifdef NOTE_PLAYER_DECAY_EN
        test_decay();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
